// File: rtl/tlul_cmd_host_pkg.sv
// Shared state encoding and opcode-selection helpers for the single-outstanding
// TL-UL command host.
package tlul_cmd_host_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReqA  = 2'd1,
        StWaitD = 2'd2,
        StRsp   = 2'd3
    } host_state_e;

    localparam logic [3:0] MaskFull = 4'hF;
    localparam logic [1:0] WordSize = 2'd2;

    function automatic tlul_pkg::tl_a_op_e sel_a_opcode(input logic write, input logic [3:0] mask);
        if (!write) begin
            return tlul_pkg::Get;
        end else if (mask == MaskFull) begin
            return tlul_pkg::PutFullData;
        end else begin
            return tlul_pkg::PutPartialData;
        end
    endfunction

    function automatic tlul_pkg::tl_d_op_e expected_d_opcode(input logic write);
        return write ? tlul_pkg::AccessAck : tlul_pkg::AccessAckData;
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types used by the command host: host-to-device and
// device-to-host structs, opcode enums and the default A-channel user bits.
package tlul_pkg;

    localparam int unsigned TL_AW  = 32;
    localparam int unsigned TL_DW  = 32;
    localparam int unsigned TL_AIW = 8;
    localparam int unsigned TL_DIW = 1;
    localparam int unsigned TL_DBW = 4;
    localparam int unsigned TL_SZW = 2;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1,
        HintAck       = 3'h2
    } tl_d_op_e;

    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    localparam tl_a_user_t TL_A_USER_DEFAULT = '{cmd_intg: 7'h0, data_intg: 7'h0};

    typedef struct packed {
        logic                a_valid;
        tl_a_op_e            a_opcode;
        logic [2:0]          a_param;
        logic [TL_SZW-1:0]   a_size;
        logic [TL_AIW-1:0]   a_source;
        logic [TL_AW-1:0]    a_address;
        logic [TL_DBW-1:0]   a_mask;
        logic [TL_DW-1:0]    a_data;
        tl_a_user_t          a_user;
        logic                d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                d_valid;
        tl_d_op_e            d_opcode;
        logic [2:0]          d_param;
        logic [TL_SZW-1:0]   d_size;
        logic [TL_AIW-1:0]   d_source;
        logic [TL_DIW-1:0]   d_sink;
        logic [TL_DW-1:0]    d_data;
        tl_d_user_t          d_user;
        logic                d_error;
        logic                a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_cmd_host_timer.sv
// Transaction watchdog: cleared on command accept, counts while enabled and
// flags the cycle in which the count reaches TimeoutCycles-1.
module tlul_cmd_host_timer #(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    // Expiry is flagged one count early so the abort lands on the cycle whose
    // increment would reach TimeoutCycles-1.
    localparam logic [15:0] ExpireAt = 16'(TimeoutCycles - 32'd2);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        expired_q;

    // Next count: clear wins, otherwise saturating increment while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 16'h0;
        end else if (enable_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'h1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter and registered expiry flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= 16'h0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d == ExpireAt);
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/tlul_cmd_host.sv
// Simple command port to TL-UL host bridge with one transaction in flight,
// a rolling source tag and a response watchdog.
module tlul_cmd_host
    import tlul_cmd_host_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned SrcW          = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [31:0]       cmd_addr_i,
    input  logic [31:0]       cmd_wdata_i,
    input  logic [3:0]        cmd_mask_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output tlul_pkg::tl_h2d_t tl_o,
    input  tlul_pkg::tl_d2h_t tl_i
);

    localparam int unsigned AiW = tlul_pkg::TL_AIW;

    host_state_e          state_q;
    logic                 cmd_ready_q;
    logic                 rsp_valid_q;
    logic                 a_valid_q;
    logic                 d_ready_q;
    logic                 write_q;
    logic                 err_q;
    logic                 timeout_q;
    logic [SrcW-1:0]      tag_q;
    logic [SrcW-1:0]      src_q;
    tlul_pkg::tl_a_op_e   opcode_q;
    logic [31:0]          addr_q;
    logic [31:0]          wdata_q;
    logic [3:0]           mask_q;
    logic [31:0]          rdata_q;

    logic                 timer_clear_s;
    logic                 timer_en_s;
    logic                 expired_s;
    logic [AiW-1:0]       src_ext_s;
    logic                 d_match_s;
    logic                 d_err_s;
    logic                 unused_s;

    assign timer_clear_s = (state_q == StIdle) && cmd_valid_i;
    assign timer_en_s    = (state_q == StReqA) || (state_q == StWaitD);
    assign src_ext_s     = AiW'(src_q);
    assign d_match_s     = tl_i.d_valid && (tl_i.d_source == src_ext_s);
    assign d_err_s       = tl_i.d_error || (tl_i.d_opcode != expected_d_opcode(write_q));
    assign unused_s      = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

    tlul_cmd_host_timer #(
        .TimeoutCycles (TimeoutCycles)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (timer_clear_s),
        .enable_i  (timer_en_s),
        .expired_o (expired_s)
    );

    // Transaction FSM with all handshake and response outputs registered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            a_valid_q   <= 1'b0;
            d_ready_q   <= 1'b1;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            tag_q       <= '0;
            src_q       <= '0;
            opcode_q    <= tlul_pkg::Get;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            mask_q      <= MaskFull;
            rdata_q     <= 32'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        state_q     <= StReqA;
                        cmd_ready_q <= 1'b0;
                        a_valid_q   <= 1'b1;
                        write_q     <= cmd_write_i;
                        opcode_q    <= sel_a_opcode(cmd_write_i, cmd_mask_i);
                        addr_q      <= {cmd_addr_i[31:2], 2'b00};
                        wdata_q     <= cmd_write_i ? cmd_wdata_i : 32'h0;
                        mask_q      <= cmd_write_i ? cmd_mask_i : MaskFull;
                        src_q       <= tag_q;
                        tag_q       <= tag_q + SrcW'(1);
                    end
                end
                StReqA: begin
                    if (expired_s) begin
                        state_q     <= StRsp;
                        a_valid_q   <= 1'b0;
                        d_ready_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        timeout_q   <= 1'b1;
                        rdata_q     <= 32'h0;
                    end else if (tl_i.a_ready) begin
                        state_q   <= StWaitD;
                        a_valid_q <= 1'b0;
                    end
                end
                StWaitD: begin
                    // A matching response beats the watchdog in the same cycle.
                    if (d_match_s) begin
                        state_q     <= StRsp;
                        d_ready_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        err_q       <= d_err_s;
                        timeout_q   <= 1'b0;
                        rdata_q     <= (d_err_s || write_q) ? 32'h0 : tl_i.d_data;
                    end else if (expired_s) begin
                        state_q     <= StRsp;
                        d_ready_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        timeout_q   <= 1'b1;
                        rdata_q     <= 32'h0;
                    end
                end
                StRsp: begin
                    if (rsp_ready_i) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        d_ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    a_valid_q   <= 1'b0;
                    d_ready_q   <= 1'b1;
                end
            endcase
        end
    end

    // Drive the TL-UL host channel from the registered command fields.
    always_comb begin
        tl_o           = '0;
        tl_o.a_valid   = a_valid_q;
        tl_o.a_opcode  = opcode_q;
        tl_o.a_param   = 3'h0;
        tl_o.a_size    = WordSize;
        tl_o.a_source  = src_ext_s;
        tl_o.a_address = addr_q;
        tl_o.a_mask    = mask_q;
        tl_o.a_data    = wdata_q;
        tl_o.a_user    = tlul_pkg::TL_A_USER_DEFAULT;
        tl_o.d_ready   = d_ready_q;
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = timeout_q;

endmodule

// File: tb/tb_tlul_cmd_host.sv
// Self-checking bench for tlul_cmd_host: directed scenarios plus randomized
// transactions compared against a cycle-count and tag model.
module tb_tlul_cmd_host;
    import tlul_pkg::*;

    localparam int TC = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_mask;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    tl_h2d_t     tl_h;
    tl_d2h_t     tl_d;

    always #5 clk = ~clk;

    tlul_cmd_host #(.TimeoutCycles(TC), .SrcW(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_mask_i(cmd_mask),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout), .tl_o(tl_h), .tl_i(tl_d)
    );

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    logic [3:0]  exp_tag;

    logic        o_acc, o_a_ok, o_err, o_tmo, o_stable, o_release;
    logic [2:0]  o_op, o_param;
    logic [31:0] o_addr, o_data, o_rdata;
    logic [3:0]  o_mask;
    logic [7:0]  o_src;
    logic [1:0]  o_size;
    logic [13:0] o_user;
    int          o_lat;

    // Reference model: the D response lands in cycle 2+a+d after accept; the
    // watchdog allows responses up to cycle TC-1, otherwise rsp appears at TC.
    function automatic int m_lat(input int a, input int d);
        return (2 + a + d <= TC - 1) ? (3 + a + d) : TC;
    endfunction
    function automatic bit m_tmo(input int a, input int d);
        return (2 + a + d > TC - 1);
    endfunction
    function automatic logic [2:0] m_op(input bit wr, input logic [3:0] m);
        return !wr ? 3'h4 : ((m == 4'hF) ? 3'h0 : 3'h1);
    endfunction

    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask, input int a_dly, input int d_dly,
                           input int stale_c, input bit derr, input bit bad_op,
                           input logic [31:0] ddata, input int rsp_dly);
        tl_d_op_e good_op;
        tl_d_op_e wrong_op;
        good_op  = wr ? AccessAck : AccessAckData;
        wrong_op = wr ? AccessAckData : AccessAck;
        @(negedge clk);
        o_acc = cmd_ready;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_mask = mask;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_addr = $urandom(); cmd_wdata = $urandom(); cmd_mask = 4'($urandom());
        o_lat = -1; o_a_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (rsp_valid) begin
                o_lat = c;
                break;
            end
            if (c == 1) begin
                o_op = tl_h.a_opcode; o_addr = tl_h.a_address; o_data = tl_h.a_data;
                o_mask = tl_h.a_mask; o_src = tl_h.a_source; o_size = tl_h.a_size;
                o_param = tl_h.a_param; o_user = tl_h.a_user;
            end
            if (c <= 1 + a_dly) begin
                if (!tl_h.a_valid || tl_h.a_address !== o_addr || tl_h.a_data !== o_data) o_a_ok = 1'b0;
            end else if (tl_h.a_valid || !tl_h.d_ready) begin
                o_a_ok = 1'b0;
            end
            tl_d.a_ready = (c == 1 + a_dly);
            tl_d.d_valid = 1'b0; tl_d.d_error = 1'b0; tl_d.d_opcode = good_op;
            tl_d.d_data = $urandom(); tl_d.d_source = 8'($urandom());
            if (c == 2 + a_dly + d_dly) begin
                tl_d.d_valid = 1'b1; tl_d.d_source = o_src; tl_d.d_error = derr;
                tl_d.d_opcode = bad_op ? wrong_op : good_op; tl_d.d_data = ddata;
            end else if (c == stale_c) begin
                tl_d.d_valid = 1'b1; tl_d.d_source = o_src ^ 8'h01;
            end
            @(negedge clk);
        end
        tl_d.a_ready = 1'b0; tl_d.d_valid = 1'b0;
        o_rdata = rsp_rdata; o_err = rsp_err; o_tmo = rsp_timeout;
        o_stable = 1'b1; o_release = 1'b0;
        if (o_lat >= 0) begin
            for (int i = 0; i < rsp_dly; i++) begin
                @(negedge clk);
                if (!rsp_valid || rsp_rdata !== o_rdata || rsp_err !== o_err ||
                    rsp_timeout !== o_tmo || cmd_ready || tl_h.a_valid || tl_h.d_ready) o_stable = 1'b0;
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            o_release = !rsp_valid && cmd_ready && tl_h.d_ready;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0;
        cmd_wdata = 32'h0; cmd_mask = 4'h0; rsp_ready = 1'b0; tl_d = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_tag = 4'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; tl_d = '0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout} !== 4'b1000)
            $display("FAIL reset_ctrl: got %b want 1000", {cmd_ready, rsp_valid, rsp_err, rsp_timeout});
        else pass_cnt++;
        chk_cnt++;
        if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rsp_rdata);
        else pass_cnt++;
        chk_cnt++;
        if ({tl_h.a_valid, tl_h.d_ready, tl_h.a_source} !== {1'b0, 1'b1, 8'h00})
            $display("FAIL reset_tl: got a_valid=%b d_ready=%b src=%h want 0 1 00", tl_h.a_valid, tl_h.d_ready, tl_h.a_source);
        else pass_cnt++;
        rst_n = 1'b1;
        exp_tag = 4'h0;
    endtask

    task automatic test_read();
        run_txn(1'b0, 32'h0000_0104, 32'h5555_AAAA, 4'h2, 0, 0, -1, 1'b0, 1'b0, 32'hDEAD_BEEF, 0);
        chk_cnt++;
        if ({o_acc, o_op, o_mask, o_addr, o_data, o_src, o_size, o_param, o_user} !==
            {1'b1, 3'h4, 4'hF, 32'h0000_0104, 32'h0, 4'h0, exp_tag, 2'h2, 3'h0, 14'h0})
            $display("FAIL read_afields: got op=%h mask=%h addr=%h data=%h src=%h size=%h want 4 f 00000104 0 %h 2",
                     o_op, o_mask, o_addr, o_data, o_src, o_size, exp_tag);
        else pass_cnt++;
        chk_cnt++;
        if (o_lat !== 3) $display("FAIL read_latency: got %0d want 3", o_lat);
        else pass_cnt++;
        chk_cnt++;
        if ({o_rdata, o_err, o_tmo} !== {32'hDEAD_BEEF, 1'b0, 1'b0})
            $display("FAIL read_rsp: got rdata=%h err=%b tmo=%b want deadbeef 0 0", o_rdata, o_err, o_tmo);
        else pass_cnt++;
        exp_tag++;
    endtask

    task automatic test_write();
        run_txn(1'b1, 32'h0000_0013, 32'h1234_5678, 4'h3, 1, 2, -1, 1'b0, 1'b0, 32'hFFFF_0000, 0);
        chk_cnt++;
        if ({o_op, o_mask, o_addr, o_data, o_src} !== {3'h1, 4'h3, 32'h10, 32'h1234_5678, 4'h0, exp_tag})
            $display("FAIL write_afields: got op=%h mask=%h addr=%h data=%h src=%h want 1 3 00000010 12345678 %h",
                     o_op, o_mask, o_addr, o_data, o_src, exp_tag);
        else pass_cnt++;
        chk_cnt++;
        if ({o_lat, o_rdata, o_err, o_tmo, o_a_ok} !== {32'd6, 32'h0, 1'b0, 1'b0, 1'b1})
            $display("FAIL write_rsp: got lat=%0d rdata=%h err=%b tmo=%b aok=%b want 6 0 0 0 1", o_lat, o_rdata, o_err, o_tmo, o_a_ok);
        else pass_cnt++;
        exp_tag++;
        run_txn(1'b1, 32'h0000_0020, 32'hA5A5_5A5A, 4'hF, 0, 0, -1, 1'b0, 1'b0, 32'h0, 0);
        chk_cnt++;
        if ({o_op, o_mask, o_rdata, o_err} !== {3'h0, 4'hF, 32'h0, 1'b0})
            $display("FAIL write_full: got op=%h mask=%h rdata=%h err=%b want 0 f 0 0", o_op, o_mask, o_rdata, o_err);
        else pass_cnt++;
        exp_tag++;
    endtask

    task automatic test_timeout();
        run_txn(1'b0, 32'h40, 32'h0, 4'hF, 100, 0, -1, 1'b0, 1'b0, 32'h1, 0);
        chk_cnt++;
        if ({o_lat, o_err, o_tmo, o_rdata, o_a_ok} !== {32'd8, 1'b1, 1'b1, 32'h0, 1'b1})
            $display("FAIL timeout_reqa: got lat=%0d err=%b tmo=%b rdata=%h aok=%b want 8 1 1 0 1", o_lat, o_err, o_tmo, o_rdata, o_a_ok);
        else pass_cnt++;
        exp_tag++;
        run_txn(1'b0, 32'h44, 32'h0, 4'hF, 1, 5, -1, 1'b0, 1'b0, 32'h1, 0);
        chk_cnt++;
        if ({o_lat, o_err, o_tmo} !== {32'd8, 1'b1, 1'b1})
            $display("FAIL timeout_waitd: got lat=%0d err=%b tmo=%b want 8 1 1", o_lat, o_err, o_tmo);
        else pass_cnt++;
        exp_tag++;
        // Late response for the aborted transaction arriving while idle.
        @(negedge clk);
        tl_d.d_valid = 1'b1; tl_d.d_source = o_src; tl_d.d_opcode = AccessAckData;
        @(negedge clk);
        tl_d.d_valid = 1'b0;
        chk_cnt++;
        if ({rsp_valid, cmd_ready, tl_h.d_ready} !== 3'b011)
            $display("FAIL timeout_late_idle: got rsp=%b rdy=%b dready=%b want 0 1 1", rsp_valid, cmd_ready, tl_h.d_ready);
        else pass_cnt++;
        run_txn(1'b0, 32'h48, 32'h0, 4'hF, 0, 5, -1, 1'b0, 1'b0, 32'hC0DE_0001, 0);
        chk_cnt++;
        if ({o_lat, o_err, o_tmo, o_rdata} !== {32'd8, 1'b0, 1'b0, 32'hC0DE_0001})
            $display("FAIL timeout_edge_priority: got lat=%0d err=%b tmo=%b rdata=%h want 8 0 0 c0de0001", o_lat, o_err, o_tmo, o_rdata);
        else pass_cnt++;
        exp_tag++;
    endtask

    task automatic test_stale();
        run_txn(1'b0, 32'h80, 32'h0, 4'hF, 0, 3, 2, 1'b0, 1'b0, 32'h0BAD_F00D, 0);
        chk_cnt++;
        if ({o_lat, o_err, o_tmo, o_rdata} !== {32'd6, 1'b0, 1'b0, 32'h0BAD_F00D})
            $display("FAIL stale_waitd: got lat=%0d err=%b tmo=%b rdata=%h want 6 0 0 0badf00d", o_lat, o_err, o_tmo, o_rdata);
        else pass_cnt++;
        exp_tag++;
        run_txn(1'b0, 32'h84, 32'h0, 4'hF, 0, 0, -1, 1'b1, 1'b0, 32'h1111_2222, 0);
        chk_cnt++;
        if ({o_err, o_tmo, o_rdata} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL derror: got err=%b tmo=%b rdata=%h want 1 0 0", o_err, o_tmo, o_rdata);
        else pass_cnt++;
        exp_tag++;
        run_txn(1'b0, 32'h88, 32'h0, 4'hF, 0, 0, -1, 1'b0, 1'b1, 32'h3333_4444, 0);
        chk_cnt++;
        if ({o_err, o_tmo, o_rdata} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL opcode_mismatch: got err=%b tmo=%b rdata=%h want 1 0 0", o_err, o_tmo, o_rdata);
        else pass_cnt++;
        exp_tag++;
    endtask

    task automatic test_backpressure();
        run_txn(1'b0, 32'hC0, 32'h0, 4'hF, 0, 0, -1, 1'b0, 1'b0, 32'h7777_8888, 5);
        chk_cnt++;
        if ({o_stable, o_release, o_rdata} !== {1'b1, 1'b1, 32'h7777_8888})
            $display("FAIL backpressure: got stable=%b release=%b rdata=%h want 1 1 77778888", o_stable, o_release, o_rdata);
        else pass_cnt++;
        exp_tag++;
    endtask

    task automatic test_random();
        bit wr, derr, bad;
        int a, d, st, rd;
        logic [31:0] addr, wd, dd, exp_rdata;
        logic [3:0] m;
        bit et, ee;
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1)); addr = $urandom(); wd = $urandom(); dd = $urandom();
            m = 4'($urandom()); a = $urandom_range(0, 4); d = $urandom_range(0, 4);
            st = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : -1;
            derr = ($urandom_range(0, 3) == 0); bad = ($urandom_range(0, 3) == 0);
            rd = $urandom_range(0, 3);
            run_txn(wr, addr, wd, m, a, d, st, derr, bad, dd, rd);
            et = m_tmo(a, d);
            ee = et | derr | bad;
            exp_rdata = (wr || ee) ? 32'h0 : dd;
            chk_cnt++;
            if ({o_op, o_mask, o_addr, o_data, o_src} !==
                {m_op(wr, m), (wr ? m : 4'hF), addr[31:2], 2'b00, (wr ? wd : 32'h0), 4'h0, exp_tag})
                $display("FAIL rand_afields[%0d]: got op=%h mask=%h addr=%h data=%h src=%h", n, o_op, o_mask, o_addr, o_data, o_src);
            else pass_cnt++;
            chk_cnt++;
            if (o_lat !== m_lat(a, d)) $display("FAIL rand_latency[%0d]: got %0d want %0d", n, o_lat, m_lat(a, d));
            else pass_cnt++;
            chk_cnt++;
            if ({o_err, o_tmo, o_rdata} !== {ee, et, exp_rdata})
                $display("FAIL rand_rsp[%0d]: got err=%b tmo=%b rdata=%h want %b %b %h", n, o_err, o_tmo, o_rdata, ee, et, exp_rdata);
            else pass_cnt++;
            chk_cnt++;
            if ({o_acc, o_a_ok, o_stable, o_release} !== 4'b1111)
                $display("FAIL rand_handshake[%0d]: got acc=%b aok=%b stable=%b release=%b want 1111", n, o_acc, o_a_ok, o_stable, o_release);
            else pass_cnt++;
            exp_tag++;
        end
    endtask

    task automatic test_wrap();
        logic [7:0] prev_src;
        apply_reset();
        prev_src = 8'hFF;
        for (int n = 0; n < 17; n++) begin
            prev_src = o_src;
            run_txn(1'b0, 32'h100, 32'h0, 4'hF, 0, 0, -1, 1'b0, 1'b0, 32'h0, 0);
            chk_cnt++;
            if (o_src !== {4'h0, exp_tag}) $display("FAIL wrap_src[%0d]: got %h want %h", n, o_src, exp_tag);
            else pass_cnt++;
            exp_tag++;
        end
        chk_cnt++;
        if ({prev_src, o_src} !== {8'h0F, 8'h00})
            $display("FAIL wrap_boundary: got %h->%h want 0f->00", prev_src, o_src);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] old_src;
        bit quiet;
        run_txn(1'b0, 32'h200, 32'h0, 4'hF, 0, 0, -1, 1'b0, 1'b0, 32'hCAFE_F00D, 0);
        exp_tag++;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h204;
        @(negedge clk);
        cmd_valid = 1'b0; old_src = tl_h.a_source; tl_d.a_ready = 1'b1;
        @(negedge clk);
        tl_d.a_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, tl_h.a_valid, tl_h.d_ready} !== 6'b100001)
            $display("FAIL midrst_ctrl: got %b want 100001", {cmd_ready, rsp_valid, rsp_err, rsp_timeout, tl_h.a_valid, tl_h.d_ready});
        else pass_cnt++;
        chk_cnt++;
        if ({rsp_rdata, tl_h.a_source} !== {32'h0, 8'h00})
            $display("FAIL midrst_data: got rdata=%h src=%h want 0 00", rsp_rdata, tl_h.a_source);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        exp_tag = 4'h0;
        tl_d.d_valid = 1'b1; tl_d.d_source = old_src; tl_d.d_opcode = AccessAckData; tl_d.d_data = 32'h1;
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tl_d.d_valid = 1'b0;
            if (rsp_valid || !cmd_ready) quiet = 1'b0;
        end
        chk_cnt++;
        if (quiet !== 1'b1) $display("FAIL midrst_no_rsp: got quiet=%b want 1", quiet);
        else pass_cnt++;
        run_txn(1'b0, 32'h208, 32'h0, 4'hF, 0, 0, -1, 1'b0, 1'b0, 32'h2468_ACE0, 0);
        chk_cnt++;
        if ({o_src, o_rdata, o_err} !== {8'h00, 32'h2468_ACE0, 1'b0})
            $display("FAIL midrst_next: got src=%h rdata=%h err=%b want 00 2468ace0 0", o_src, o_rdata, o_err);
        else pass_cnt++;
        exp_tag++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        o_src = 8'h00;
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_stale();
        test_backpressure();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
